// File: rtl/instr_field_splitter.sv
// rtl/instr_field_splitter.sv - registered MIPS-32 field splitter with R/I/J/illegal classification (optional SPLIT_EXT_IMM_EN adds extended immediates)
module instr_field_splitter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instruction,
`ifdef SPLIT_EXT_IMM_EN
  output logic [31:0] imm_sext,
  output logic [31:0] imm_zext,
`endif
  output logic        out_valid,
  output logic [5:0]  opc,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [5:0]  fun,
  output logic [15:0] imm,
  output logic [25:0] iindex,
  output logic [1:0]  itype,
  output logic        illegal
);

  localparam logic [1:0] ITYPE_I   = 2'b00;
  localparam logic [1:0] ITYPE_J   = 2'b01;
  localparam logic [1:0] ITYPE_R   = 2'b10;
  localparam logic [1:0] ITYPE_ILL = 2'b11;

  logic [31:0] instr_q;
  logic [1:0]  itype_q;
  logic        valid_q;
  logic [1:0]  itype_next;

  logic [5:0] in_opc;
  logic [4:0] in_rs;
  logic [4:0] in_rt;
  logic [5:0] in_fun;

  assign in_opc = instruction[31:26];
  assign in_rs  = instruction[25:21];
  assign in_rt  = instruction[20:16];
  assign in_fun = instruction[5:0];

  // Classify the incoming word; opcode decides first, qualifier fields only refine it.
  always_comb begin
    itype_next = ITYPE_ILL;
    casez (in_opc)
      6'b10?011, 6'b001???, 6'b00010?: itype_next = ITYPE_I;
      6'b000001: begin
        if (in_rt[4:1] == 4'b0000) itype_next = ITYPE_I;
      end
      6'b00011?: begin
        if (in_rt == 5'b00000) itype_next = ITYPE_I;
      end
      6'b000000: begin
        if ((in_fun[5:3] == 3'b100) || (in_fun == 6'b000010) ||
            (in_fun[5:1] == 5'b10101) || (in_fun == 6'b001000) ||
            (in_fun == 6'b001010) || (in_fun == 6'b001100))
          itype_next = ITYPE_R;
      end
      6'b010000: begin
        if (((in_fun == 6'b011000) && (in_rs == 5'b10000)) ||
            (in_rs == 5'b00100) || (in_rs == 5'b00000))
          itype_next = ITYPE_R;
      end
      6'b00001?: itype_next = ITYPE_J;
      default: itype_next = ITYPE_ILL;
    endcase
  end

  // Capture word and class on valid; otherwise hold them and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 32'h0;
      itype_q <= ITYPE_I;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        instr_q <= instruction;
        itype_q <= itype_next;
      end
    end
  end

  assign out_valid = valid_q;
  assign opc       = instr_q[31:26];
  assign rs        = instr_q[25:21];
  assign rt        = instr_q[20:16];
  assign rd        = instr_q[15:11];
  assign sa        = instr_q[10:6];
  assign fun       = instr_q[5:0];
  assign imm       = instr_q[15:0];
  assign iindex    = instr_q[25:0];
  assign itype     = itype_q;
  assign illegal   = (itype_q == ITYPE_ILL);

`ifdef SPLIT_EXT_IMM_EN
  // Extended immediates come straight off the captured word, so they reset and hold with it.
  assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};
  assign imm_zext = {16'h0, instr_q[15:0]};
`else
  // Only the raw 16-bit immediate slice is presented in this build.
`endif

endmodule

// File: tb/tb_instr_field_splitter.sv
// tb/tb_instr_field_splitter.sv - scoreboard bench for instr_field_splitter
module tb_instr_field_splitter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_valid;
  logic [5:0]  opc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [5:0]  fun;
  logic [15:0] imm;
  logic [25:0] iindex;
  logic [1:0]  itype;
  logic        illegal;
`ifdef SPLIT_EXT_IMM_EN
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
`endif

  instr_field_splitter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .instruction (instruction),
`ifdef SPLIT_EXT_IMM_EN
    .imm_sext    (imm_sext),
    .imm_zext    (imm_zext),
`endif
    .out_valid   (out_valid),
    .opc         (opc),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .sa          (sa),
    .fun         (fun),
    .imm         (imm),
    .iindex      (iindex),
    .itype       (itype),
    .illegal     (illegal)
  );

  typedef struct {
    logic [31:0] word;
    logic [1:0]  cls;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference classification computed from opcode numbers and field values.
  function automatic logic [1:0] ref_class(input logic [31:0] w);
    int o, s, t, f;
    o = int'((w >> 26) & 32'h3f);
    s = int'((w >> 21) & 32'h1f);
    t = int'((w >> 16) & 32'h1f);
    f = int'(w & 32'h3f);
    if (o inside {4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43}) return 2'd0;
    if (o == 1) return (t <= 1) ? 2'd0 : 2'd3;
    if (o == 6 || o == 7) return (t == 0) ? 2'd0 : 2'd3;
    if (o == 0) begin
      if ((f >= 32 && f <= 39) || f == 2 || f == 42 || f == 43 || f == 8 || f == 10 || f == 12)
        return 2'd2;
      return 2'd3;
    end
    if (o == 16) begin
      if ((f == 24 && s == 16) || s == 4 || s == 0) return 2'd2;
      return 2'd3;
    end
    if (o == 2 || o == 3) return 2'd1;
    return 2'd3;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, "_opc"},     {26'd0, opc},    (e.word >> 26) & 32'h3f);
    check({tag, "_rs"},      {27'd0, rs},     (e.word >> 21) & 32'h1f);
    check({tag, "_rt"},      {27'd0, rt},     (e.word >> 16) & 32'h1f);
    check({tag, "_rd"},      {27'd0, rd},     (e.word >> 11) & 32'h1f);
    check({tag, "_sa"},      {27'd0, sa},     (e.word >> 6) & 32'h1f);
    check({tag, "_fun"},     {26'd0, fun},    e.word & 32'h3f);
    check({tag, "_imm"},     {16'd0, imm},    e.word % 32'h10000);
    check({tag, "_iindex"},  {6'd0, iindex},  e.word % 32'h4000000);
    check({tag, "_itype"},   {30'd0, itype},  {30'd0, e.cls});
    check({tag, "_illegal"}, {31'd0, illegal}, (e.cls == 2'd3) ? 32'd1 : 32'd0);
`ifdef SPLIT_EXT_IMM_EN
    check({tag, "_imm_zext"}, imm_zext, e.word % 32'h10000);
    check({tag, "_imm_sext"}, imm_sext,
          ((e.word % 32'h10000) >= 32'h8000) ? ((e.word % 32'h10000) + 32'hFFFF0000) : (e.word % 32'h10000));
`endif
  endtask

  function automatic logic [31:0] rand_word();
    int opcs[17] = '{0, 0, 0, 1, 2, 3, 4, 6, 7, 8, 12, 15, 16, 16, 35, 43, 63};
    int funs[9]  = '{32, 37, 39, 2, 42, 43, 8, 10, 24};
    int o, s, t, f;
    o = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63)) : opcs[$urandom_range(0, 16)];
    case ($urandom_range(0, 3))
      0: s = 0;
      1: s = 4;
      2: s = 16;
      default: s = int'($urandom_range(0, 31));
    endcase
    case ($urandom_range(0, 3))
      0: t = 0;
      1: t = 1;
      2: t = 2;
      default: t = int'($urandom_range(0, 31));
    endcase
    f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 63)) : funs[$urandom_range(0, 8)];
    return (32'(o) << 26) | (32'(s) << 21) | (32'(t) << 16) |
           ($urandom & 32'h0000_ffc0) | 32'(f);
  endfunction

  // Monitor: pops an expectation per out_valid, otherwise checks that fields hold.
  initial begin
    exp_t e;
    last_exp = '{32'h0, 2'd0};
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_outputs("cap", e);
          last_exp = e;
        end
      end else begin
        check_outputs("hold", last_exp);
      end
    end
  end

  task automatic drive(input logic [31:0] w, input logic [1:0] cls);
    in_valid    = 1'b1;
    instruction = w;
    sb.push_back('{w, cls});
  endtask

  initial begin
    logic [31:0] dir_word [6];
    logic [1:0]  dir_cls  [6];
    logic [31:0] w;
    int          waited;
    dir_word = '{32'h00221820, 32'h2022FFFF, 32'h08123456, 32'hFC000000, 32'h04020004, 32'h04010004};
    dir_cls  = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd3, 2'd0};
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    instruction = 32'h0;
    #3;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_outputs("reset", '{32'h0, 2'd0});

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Directed words back to back, expectations from hand-derived classes.
    for (int i = 0; i < 6; i++) begin
      drive(dir_word[i], dir_cls[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    instruction = 32'hDEADBEEF;
    repeat (3) @(negedge clk);

    // Randomized stream with gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        w = rand_word();
        drive(w, ref_class(w));
      end else begin
        in_valid = 1'b0;
        instruction = $urandom;
      end
      @(negedge clk);
    end

    // Mid-stream asynchronous reset while a capture is pending and in_valid stays high.
    drive(32'h8C43FFFC, ref_class(32'h8C43FFFC));
    @(posedge clk);
    #1;
    instruction = 32'h00221820;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_outputs("midrst", '{32'h0, 2'd0});
    sb.delete();
    last_exp = '{32'h0, 2'd0};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      w = rand_word();
      drive(w, ref_class(w));
      @(negedge clk);
    end
    in_valid = 1'b0;

    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("drain_queue_empty", sb.size(), 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
